// File: rtl/mul_seq_if.sv
// Request/result handshake bundle for the iterative multiplier.
// Default opcode encodings are provided here when defines.vh is not in scope.
`ifndef ALU_MUL
`define ALU_MUL    5'b01100
`endif
`ifndef ALU_MULH
`define ALU_MULH   5'b01101
`endif
`ifndef ALU_MULHSU
`define ALU_MULHSU 5'b01110
`endif
`ifndef ALU_MULHU
`define ALU_MULHU  5'b01111
`endif

interface mul_seq_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [4:0]      opcode;
  logic [XLEN-1:0] rs1;
  logic [XLEN-1:0] rs2;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] rd;

  modport master (
    output in_valid, opcode, rs1, rs2, out_ready,
    input  in_ready, out_valid, rd
  );

  modport slave (
    input  in_valid, opcode, rs1, rs2, out_ready,
    output in_ready, out_valid, rd
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative shift-add multiplier for MUL/MULH/MULHSU/MULHU (sign-magnitude core).
// Define MUL_RADIX4_EN to retire two multiplier bits per BUSY cycle.
module mul_seq #(
  parameter int XLEN = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     flush,
  mul_seq_if.slave bus
);

  localparam int PW = 2 * XLEN;
`ifdef MUL_RADIX4_EN
  localparam int STEPS = XLEN / 2;
`else
  localparam int STEPS = XLEN;
`endif
  localparam int CW = $clog2(STEPS);

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t          state, state_nx;
  logic [4:0]      op_q;
  logic [PW-1:0]   mcand_q;
  logic [PW-1:0]   acc_q;
  logic [XLEN-1:0] mplier_q;
  logic [XLEN-1:0] rd_q;
  logic            neg_q;
  logic [CW-1:0]   cnt_q;

  logic            accept;
  logic            s1, s2;
  logic [PW-1:0]   partial;
  logic [PW-1:0]   prod;

  function automatic logic is_mul_op(input logic [4:0] op);
    return (op == `ALU_MUL) || (op == `ALU_MULH) ||
           (op == `ALU_MULHSU) || (op == `ALU_MULHU);
  endfunction

  // |-2^(XLEN-1)| wraps to 2^(XLEN-1), which is exactly right as an unsigned magnitude
  function automatic logic [XLEN-1:0] mag(input logic signed [XLEN-1:0] x,
                                          input logic as_signed);
    return (as_signed && x[XLEN-1]) ? -x : x;
  endfunction

  function automatic logic [PW-1:0] cneg(input logic [PW-1:0] p, input logic n);
    return n ? (~p + 1'b1) : p;
  endfunction

  assign s1     = (bus.opcode == `ALU_MULH) || (bus.opcode == `ALU_MULHSU);
  assign s2     = (bus.opcode == `ALU_MULH);
  assign accept = bus.in_valid && bus.in_ready;
  assign prod   = cneg(acc_q, neg_q);
  assign bus.rd = rd_q;

  always_comb begin
    partial = '0;
`ifdef MUL_RADIX4_EN
    case (mplier_q[1:0])
      2'd1:    partial = mcand_q;
      2'd2:    partial = mcand_q << 1;
      2'd3:    partial = mcand_q + (mcand_q << 1);
      default: partial = '0;
    endcase
`else
    if (mplier_q[0]) partial = mcand_q;
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (flush) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = is_mul_op(bus.opcode) ? BUSY : DONE;
        BUSY:    if (cnt_q == '0) state_nx = FIX;
        FIX:     state_nx = DONE;
        DONE:    if (bus.out_ready) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  always_comb begin
    bus.in_ready  = (state == IDLE);
    bus.out_valid = (state == DONE);
  end

  // Datapath: operand capture, shift-add steps, sign fix-up and result select
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q     <= '0;
      mcand_q  <= '0;
      acc_q    <= '0;
      mplier_q <= '0;
      rd_q     <= '0;
      neg_q    <= 1'b0;
      cnt_q    <= '0;
    end else if (!flush) begin
      case (state)
        IDLE: if (accept) begin
          op_q     <= bus.opcode;
          mcand_q  <= PW'(mag(bus.rs1, s1));
          mplier_q <= mag(bus.rs2, s2);
          neg_q    <= (s1 & bus.rs1[XLEN-1]) ^ (s2 & bus.rs2[XLEN-1]);
          acc_q    <= '0;
          cnt_q    <= CW'(STEPS - 1);
          if (!is_mul_op(bus.opcode)) rd_q <= '0;
        end
        BUSY: begin
          acc_q <= acc_q + partial;
`ifdef MUL_RADIX4_EN
          mcand_q  <= mcand_q << 2;
          mplier_q <= mplier_q >> 2;
`else
          mcand_q  <= mcand_q << 1;
          mplier_q <= mplier_q >> 1;
`endif
          cnt_q <= cnt_q - 1'b1;
        end
        FIX: rd_q <= (op_q == `ALU_MUL) ? prod[XLEN-1:0] : prod[PW-1:XLEN];
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: directed corner cases, handshake/flush/reset
// scenarios, then randomized operations against a wide-integer reference model.
`ifndef ALU_MUL
`define ALU_MUL    5'b01100
`endif
`ifndef ALU_MULH
`define ALU_MULH   5'b01101
`endif
`ifndef ALU_MULHSU
`define ALU_MULHSU 5'b01110
`endif
`ifndef ALU_MULHU
`define ALU_MULHU  5'b01111
`endif

module tb_mul_seq;
  localparam int XLEN = 32;
`ifdef MUL_RADIX4_EN
  localparam int EXP_LAT = XLEN / 2 + 1;
`else
  localparam int EXP_LAT = XLEN + 1;
`endif

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic flush = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  mul_seq_if #(.XLEN(XLEN)) bus ();

  mul_seq #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (flush),
    .bus   (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp)
    else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic is_valid_op(input logic [4:0] op);
    return op == `ALU_MUL || op == `ALU_MULH || op == `ALU_MULHSU || op == `ALU_MULHU;
  endfunction

  // Reference: exact product in 128-bit signed arithmetic, then pick the half
  function automatic logic [31:0] ref_mul(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b);
    logic signed [127:0] a_s, a_u, b_s, b_u, p;
    a_s = $signed({{96{a[31]}}, a});
    a_u = $signed({96'd0, a});
    b_s = $signed({{96{b[31]}}, b});
    b_u = $signed({96'd0, b});
    case (op)
      `ALU_MUL:    begin p = a_u * b_u; return p[31:0];  end
      `ALU_MULH:   begin p = a_s * b_s; return p[63:32]; end
      `ALU_MULHSU: begin p = a_s * b_u; return p[63:32]; end
      `ALU_MULHU:  begin p = a_u * b_u; return p[63:32]; end
      default:     return 32'd0;
    endcase
  endfunction

  function automatic logic [31:0] rnd_opd();
    case ($urandom_range(0, 5))
      0:       return 32'h8000_0000;
      1:       return 32'hFFFF_FFFF;
      2:       return $urandom & 32'h0000_00FF;
      3:       return 32'h8000_0000 | ($urandom & 32'hF);
      default: return $urandom;
    endcase
  endfunction

  task automatic start_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
    int g;
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.opcode   = op;
    bus.rs1      = a;
    bus.rs2      = b;
    g = 0;
    while (!bus.in_ready && g < 50) begin
      @(negedge clk);
      g++;
    end
    if (g >= 50) chk("accept_timeout", 32'(bus.in_ready), 1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.rs1      = $urandom;
    bus.rs2      = $urandom;
    bus.opcode   = 5'($urandom);
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!bus.out_valid && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
    end
    if (!bus.out_valid) chk("done_timeout", 32'(bus.out_valid), 1);
  endtask

  task automatic do_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       output logic [31:0] res, output int lat);
    bus.out_ready = 1'b1;
    start_op(op, a, b);
    wait_done(lat);
    res = bus.rd;
    @(posedge clk);
    #1;
  endtask

  logic [4:0]  d_op [7] = '{`ALU_MUL, `ALU_MULH, `ALU_MULH, `ALU_MUL,
                            `ALU_MULHU, `ALU_MULHSU, `ALU_MULHSU};
  logic [31:0] d_a  [7] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0002};
  logic [31:0] d_b  [7] = '{32'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF,
                            32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
  logic [31:0] d_e  [7] = '{32'h0000_002A, 32'h4000_0000, 32'h0000_0000, 32'h8000_0000,
                            32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0001};

  initial begin
    logic [31:0] res, held;
    logic [4:0]  op;
    logic [31:0] a, b;
    int          lat, seen;

    bus.in_valid  = 1'b0;
    bus.opcode    = '0;
    bus.rs1       = '0;
    bus.rs2       = '0;
    bus.out_ready = 1'b0;

    #12;
    chk("reset_in_ready", 32'(bus.in_ready), 1);
    chk("reset_out_valid", 32'(bus.out_valid), 0);
    chk("reset_rd", bus.rd, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 7; i++) begin
      do_op(d_op[i], d_a[i], d_b[i], res, lat);
      chk($sformatf("directed_%0d_rd", i), res, d_e[i]);
      chk($sformatf("directed_%0d_lat", i), 32'(lat), 32'(EXP_LAT));
    end
    chk("idle_after_handshake", 32'(bus.in_ready), 1);

    do_op(5'd3, 32'd9, 32'd9, res, lat);
    chk("bad_opcode_rd", res, 0);
    chk("bad_opcode_lat", 32'(lat), 0);

    // Backpressure: result held while consumer stalls; new requests refused
    bus.out_ready = 1'b0;
    start_op(`ALU_MUL, 32'h1234, 32'h10);
    wait_done(lat);
    held = bus.rd;
    chk("bp_rd", held, 32'h0001_2340);
    for (int i = 0; i < 5; i++) begin
      bus.in_valid = 1'b1;
      bus.opcode   = `ALU_MUL;
      bus.rs1      = 32'd9;
      bus.rs2      = 32'd9;
      @(posedge clk);
      #1;
      chk("bp_out_valid", 32'(bus.out_valid), 1);
      chk("bp_rd_stable", bus.rd, held);
      chk("bp_in_ready", 32'(bus.in_ready), 0);
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk("bp_consumed_valid", 32'(bus.out_valid), 0);
    chk("bp_consumed_ready", 32'(bus.in_ready), 1);

    // Flush in the middle of BUSY
    start_op(`ALU_MUL, 32'hFFFF, 32'hFFFF);
    repeat (9) begin
      @(posedge clk);
      #1;
    end
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    chk("flush_in_ready", 32'(bus.in_ready), 1);
    chk("flush_out_valid", 32'(bus.out_valid), 0);
    chk("flush_rd_kept", bus.rd, held);
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen++;
    end
    chk("flush_no_valid", 32'(seen), 0);
    do_op(`ALU_MUL, 32'd3, 32'd5, res, lat);
    chk("post_flush_rd", res, 32'h0000_000F);

    // Asynchronous reset between edges while BUSY
    start_op(`ALU_MULH, 32'h7FFF_FFFF, 32'd3);
    repeat (5) begin
      @(posedge clk);
      #1;
    end
    #3;
    rst_n = 1'b0;
    #1;
    chk("areset_in_ready", 32'(bus.in_ready), 1);
    chk("areset_out_valid", 32'(bus.out_valid), 0);
    chk("areset_rd", bus.rd, 0);
    @(negedge clk);
    rst_n = 1'b1;
    do_op(`ALU_MULHU, 32'h0001_0000, 32'h0001_0000, res, lat);
    chk("post_reset_rd", res, 32'h0000_0001);

    // Randomized regression
    for (int i = 0; i < 1000; i++) begin
      case ($urandom_range(0, 9))
        0, 4:    op = `ALU_MUL;
        1, 5:    op = `ALU_MULH;
        2, 6:    op = `ALU_MULHSU;
        3, 7:    op = `ALU_MULHU;
        default: begin
          op = 5'($urandom);
          while (is_valid_op(op)) op = 5'($urandom);
        end
      endcase
      a = rnd_opd();
      b = rnd_opd();
      do_op(op, a, b, res, lat);
      chk($sformatf("rand_%0d_rd op=%0h a=%0h b=%0h", i, op, a, b), res, ref_mul(op, a, b));
      chk($sformatf("rand_%0d_lat", i), 32'(lat), is_valid_op(op) ? 32'(EXP_LAT) : 32'd0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
